// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the ALU.
// Define MULDIV_EARLY_OUT_EN to finish div-by-zero/overflow directly from IDLE.
module muldiv_sequencer #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [2:0]      MdOp,
    input  logic [XLEN-1:0] OperandA,
    input  logic [XLEN-1:0] OperandB,
    input  logic            Kill,
    output logic            Busy,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t r_state;
    state_t w_next;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_dvsr;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_cnt;

    // Zero divisor or the one signed overflow case; unsigned ops only see /0.
    function automatic logic is_special(input logic [2:0]      op,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        return op[2] && ((b == '0) ||
               (!op[0] && (a == MIN_INT) && (b == '1)));
    endfunction

    function automatic logic [XLEN-1:0] special_val(input logic [2:0]      op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        if (b == '0)
            return op[1] ? a : '1;
        return op[1] ? '0 : a;
    endfunction

    logic                w_accept;
    logic                w_neg_a_in;
    logic                w_neg_b_in;
    logic                w_sa;
    logic                w_sb;
    logic [2*XLEN-1:0]   w_ma;
    logic [2*XLEN-1:0]   w_mb;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN:0]       w_sh;
    logic [XLEN:0]       w_diff;
    logic                w_qbit;
    logic [XLEN-1:0]     w_rem_nx;
    logic [XLEN-1:0]     w_quo_nx;
    logic                w_neg_q;
    logic                w_neg_r;
    logic [XLEN-1:0]     w_q_s;
    logic [XLEN-1:0]     w_r_s;
    logic [XLEN-1:0]     w_div_res;

    assign w_accept   = Start && !Kill && (r_state == S_IDLE);
    assign w_neg_a_in = !MdOp[0] && OperandA[XLEN-1];
    assign w_neg_b_in = !MdOp[0] && OperandB[XLEN-1];

    // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact.
    assign w_sa      = (r_op[1:0] == 2'b01) || (r_op[1:0] == 2'b10);
    assign w_sb      = (r_op[1:0] == 2'b01);
    assign w_ma      = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
    assign w_mb      = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                            : w_prod[2*XLEN-1:XLEN];

    assign w_sh     = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_sh - {1'b0, r_dvsr};
    assign w_qbit   = !w_diff[XLEN];
    assign w_rem_nx = w_qbit ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_qbit};

    assign w_neg_q   = !r_op[0] && (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_neg_r   = !r_op[0] && r_a[XLEN-1];
    assign w_q_s     = w_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_s     = w_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_div_res = is_special(r_op, r_a, r_b) ? special_val(r_op, r_a, r_b)
                     : (r_op[1] ? w_r_s : w_q_s);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (Start && !Kill) begin
                    if (!MdOp[2])
                        w_next = S_MUL;
                    else begin
`ifdef MULDIV_EARLY_OUT_EN
                        w_next = is_special(MdOp, OperandA, OperandB)
                               ? S_DONE : S_DIV;
`else
                        w_next = S_DIV;
`endif
                    end
                end
            end
            S_MUL: begin
                Busy   = 1'b1;
                w_next = Kill ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                Busy = 1'b1;
                if (Kill)
                    w_next = S_IDLE;
                else if (r_cnt == LAST_ITER)
                    w_next = S_DONE;
            end
            S_DONE: begin
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        Stall = (Start && (r_state == S_IDLE)) || Busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dvsr   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= MdOp;
                r_a    <= OperandA;
                r_b    <= OperandB;
                r_dvsr <= w_neg_b_in ? -OperandB : OperandB;
                r_quo  <= w_neg_a_in ? -OperandA : OperandA;
                r_rem  <= '0;
                r_cnt  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                if (is_special(MdOp, OperandA, OperandB))
                    r_result <= special_val(MdOp, OperandA, OperandB);
`endif
            end
            if (r_state == S_MUL && !Kill)
                r_result <= w_mul_res;
            if (r_state == S_DIV && !Kill) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == LAST_ITER)
                    r_result <= w_div_res;
            end
        end
    end

    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: random and directed checks of muldiv_sequencer
// against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [2:0]  MdOp;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Kill;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN       (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .MdOp     (MdOp),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .Kill     (Kill),
        .Busy     (Busy),
        .Stall    (Stall),
        .Done     (Done),
        .Result   (Result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        ia  = a;
        ib  = b;
        sa  = ia;
        sb  = ib;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 0) ||
                  (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (!op[2])
            return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (special)
            return 1;
`endif
        if (special)
            return 33;
        return 33;
    endfunction

    // Called at a negedge with the DUT idle; that cycle becomes cycle 0.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit noise);
        int          lat;
        int          done_cyc;
        int          bad;
        logic [31:0] res;
        lat      = exp_lat(op, a, b);
        done_cyc = -1;
        bad      = 0;
        res      = 'x;
        Start    = 1'b1;
        MdOp     = op;
        OperandA = a;
        OperandB = b;
        #1;
        check($sformatf("%s stall_c0", tag), {31'b0, Stall}, 32'd1);
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (Busy !== (c < lat))  bad++;
            if (Stall !== (c < lat)) bad++;
            if (Done === 1'b1) begin
                done_cyc = c;
                res      = Result;
            end
            if (noise && done_cyc < 0) begin
                Start    = 1'($urandom_range(0, 1));
                MdOp     = 3'($urandom_range(0, 7));
                OperandA = $urandom;
                OperandB = $urandom;
            end else begin
                Start = 1'b0;
            end
        end
        check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(lat));
        check($sformatf("%s result", tag), res, exp);
        check($sformatf("%s busy_stall_profile", tag), 32'(bad), 32'd0);
        @(negedge clk);
        check($sformatf("%s held", tag), Result, exp);
        check($sformatf("%s single_done", tag), {31'b0, Done}, 32'd0);
    endtask

    // DIVU 1000/3 aborted in cycle 10 by Kill or rst, then restarted in cycle 11.
    task automatic abort_op(input string tag, input bit use_rst);
        logic [31:0] prev;
        int          dones;
        prev     = Result;
        dones    = 0;
        Start    = 1'b1;
        MdOp     = 3'b101;
        OperandA = 32'd1000;
        OperandB = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (Done === 1'b1) dones++;
            Start = 1'b0;
            if (c == 10) begin
                if (use_rst) rst = 1'b1;
                else         Kill = 1'b1;
            end
        end
        @(negedge clk);
        check($sformatf("%s busy_c11", tag), {31'b0, Busy}, 32'd0);
        check($sformatf("%s done_c11", tag), {31'b0, Done}, 32'd0);
        check($sformatf("%s stall_c11", tag), {31'b0, Stall}, 32'd0);
        check($sformatf("%s result_c11", tag), Result,
              use_rst ? 32'd0 : prev);
        check($sformatf("%s no_done", tag), 32'(dones), 32'd0);
        rst  = 1'b0;
        Kill = 1'b0;
        do_op($sformatf("%s restart", tag), 3'b101, 32'd1000, 32'd3,
              32'd333, 1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        rst      = 1'b1;
        Start    = 1'b0;
        Kill     = 1'b0;
        MdOp     = '0;
        OperandA = '0;
        OperandB = '0;
        repeat (3) @(negedge clk);
        check("reset result", Result, 32'd0);
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset done", {31'b0, Done}, 32'd0);
        check("reset stall", {31'b0, Stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op("mulhu", 3'b011, '1, '1, 32'hFFFF_FFFE, 1'b0);
        do_op("mulh", 3'b001, '1, '1, 32'h0, 1'b0);
        do_op("mulhsu", 3'b010, '1, '1, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        do_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        do_op("divu_z", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op("remu_z", 3'b111, 32'd100, 32'd0, 32'd100, 1'b0);
        do_op("div_z", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_z", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, '1, 32'h8000_0000, 1'b0);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, '1, 32'h0, 1'b0);

        abort_op("kill", 1'b0);
        abort_op("rst", 1'b1);

        a        = Result;
        Start    = 1'b1;
        Kill     = 1'b1;
        MdOp     = 3'b000;
        OperandA = 32'd3;
        OperandB = 32'd4;
        @(negedge clk);
        check("kill_start busy", {31'b0, Busy}, 32'd0);
        check("kill_start done", {31'b0, Done}, 32'd0);
        Start = 1'b0;
        Kill  = 1'b0;
        @(negedge clk);
        check("kill_start idle_done", {31'b0, Done}, 32'd0);
        check("kill_start result", Result, a);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            do_op($sformatf("rnd%0d op%0d", i, op), op, a, b,
                  model(op, a, b), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle execution unit for RV32M multiply/divide operations. It sits beside the ALU in the CPU core and accepts an operation when the instruction decoder flags an M-extension instruction. While the operation is in flight it stalls the PC/fetch path. When the operation finishes it returns a registered 32-bit result for register writeback.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `DIV_CYCLES`, 32: restoring-divide iterations. Must equal `XLEN`.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Start` input 1: request a new operation. Sampled only in IDLE.
- `MdOp` input 3: RISC-V funct3 code.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `OperandA` input 32: rs1 value.
- `OperandB` input 32: rs2 value.
- `Kill` input 1: abort the in-flight operation (pipeline flush).
- `Busy` output 1: high in the MUL and DIV states.
- `Stall` output 1: combinational, `(Start && state==IDLE) || Busy`.
- `Done` output 1: one-cycle pulse, high in the DONE state.
- `Result` output 32: registered result. Valid while `Done` is high, then held until the next accepted `Start`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with `Start`: latch `MdOp`, `OperandA` and `OperandB`.
  - MdOp[2]=0 → MUL.
  - MdOp[2]=1 → DIV, or directly to DONE on an early-out (see Configuration).
- MUL: form a 64-bit product from 33-bit extended operands.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU and MUL: both operands unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
  - Register the result, then go to DONE.
- DIV: take magnitudes for signed ops (DIV, REM).
  - Restoring division with a 33-bit partial remainder, one quotient bit per cycle, 5-bit iteration counter 0..31.
  - After iteration 31, apply signs and go to DONE:
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special results are mandatory regardless of configuration:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = `OperandA`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE → IDLE unconditionally after one cycle. `Start` seen in MUL, DIV or DONE is ignored.
- `Kill` in MUL or DIV: next state IDLE, no `Done`, `Result` unchanged.
  - `Kill` in IDLE or DONE has no effect.
  - `Kill` together with `Start` in IDLE: the request is dropped.
- Reset values: state IDLE, `Busy` 0, `Done` 0, `Result` 0x00000000, counter 0. Reset overrides `Kill` and `Start`.

## Timing
- Cycle 0 is the cycle in which `Start` is presented in IDLE; `Stall` is high in cycle 0.
- MUL family: `Busy` high in cycle 1; `Done` in cycle 2.
- Divide (full path): `Busy` high in cycles 1–32; `Done` in cycle 33.
- Early-out divide: `Done` in cycle 1; `Busy` never rises.
- `Stall` is low in the DONE cycle, so the CPU retires the instruction and writes `Result` back in that cycle.
- A back-to-back `Start` is accepted at the earliest in the cycle after `Done`.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: in IDLE, divide-by-zero and signed overflow skip the DIV state and go straight to DONE with the special result (`Done` in cycle 1).
- `MULDIV_EARLY_OUT_EN` undefined: every divide runs the full 32 iterations.
  - The special results are produced by the sign/fix-up logic at the exit of DIV.
  - `Done` is always in cycle 33.
- Result values are identical in both builds; only latency differs.

## Test plan
- MUL A=7, B=0xFFFFFFFD → `Result` 0xFFFFFFEB, `Done` in cycle 2, `Stall` high in cycles 0–1.
- A=B=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- A=0xFFFFFFF9 (−7), B=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - `Done` in cycle 33; a `Start` re-asserted during cycles 1–33 is ignored.
- A=100, B=0:
  - DIVU → 0xFFFFFFFF.
  - REMU → 100.
  - `Done` in cycle 1 with `MULDIV_EARLY_OUT_EN`, in cycle 33 without it.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Run in both builds.
- DIVU 1000/3, abort mid-operation:
  - `Kill` in cycle 10 → IDLE in cycle 11, no `Done`, `Result` unchanged.
  - Repeat with `rst` in cycle 10 → all outputs at reset values in cycle 11.
  - A new `Start` in cycle 11 completes normally with 333.
